instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 135 +++++++++++++
 tb/tb_instr_fetch.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register feeding a combinational ROM, plus a 2-entry
// registered {pc, instr} buffer toward decode. Optional macro MISALIGN_CHK_EN enables misaligned-redirect trapping.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        misalign_err
);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] e0_pc_q, e0_pc_d, e0_instr_q, e0_instr_d;
    logic [31:0] e1_pc_q, e1_pc_d, e1_instr_q, e1_instr_d;
    logic        err_q, err_d;
    logic        push_s, pop_s;

    // Handshake decode, buffer update and PC sequencing.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        e0_pc_d    = e0_pc_q;
        e0_instr_d = e0_instr_q;
        e1_pc_d    = e1_pc_q;
        e1_instr_d = e1_instr_q;
        err_d      = err_q;
        pop_s      = (state_q != EMPTY) && out_ready;
        push_s     = !redirect_valid && !err_q && ((state_q != FULL) || pop_s);
        if (redirect_valid) begin
            // An accepted head is simply dropped along with the rest of the flush.
            state_d = EMPTY;
            pc_d    = redirect_target & 32'hFFFF_FFFC;
`ifdef MISALIGN_CHK_EN
            if (redirect_target[1:0] != 2'b00) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
`else
            err_d   = 1'b0;
`endif
        end else begin
            if (push_s) begin
                pc_d = pc_q + 32'd4;
            end else begin
                pc_d = pc_q;
            end
            case (state_q)
                EMPTY: begin
                    if (push_s) begin
                        e0_pc_d    = pc_q;
                        e0_instr_d = imem_data;
                        state_d    = ONE;
                    end else begin
                        state_d    = EMPTY;
                    end
                end
                ONE: begin
                    if (push_s && pop_s) begin
                        e0_pc_d    = pc_q;
                        e0_instr_d = imem_data;
                    end else if (push_s) begin
                        e1_pc_d    = pc_q;
                        e1_instr_d = imem_data;
                        state_d    = FULL;
                    end else if (pop_s) begin
                        state_d    = EMPTY;
                    end else begin
                        state_d    = ONE;
                    end
                end
                FULL: begin
                    if (pop_s) begin
                        e0_pc_d    = e1_pc_q;
                        e0_instr_d = e1_instr_q;
                        if (push_s) begin
                            e1_pc_d    = pc_q;
                            e1_instr_d = imem_data;
                        end else begin
                            state_d    = ONE;
                        end
                    end else begin
                        state_d = FULL;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State registers with synchronous reset overriding all traffic.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            pc_q       <= RESET_PC;
            err_q      <= 1'b0;
            e0_pc_q    <= 32'h0000_0000;
            e0_instr_q <= NOP_INSTR;
            e1_pc_q    <= 32'h0000_0000;
            e1_instr_q <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            err_q      <= err_d;
            e0_pc_q    <= e0_pc_d;
            e0_instr_q <= e0_instr_d;
            e1_pc_q    <= e1_pc_d;
            e1_instr_q <= e1_instr_d;
        end
    end

    assign imem_addr    = pc_q;
    assign out_valid    = (state_q != EMPTY);
    assign out_instr    = out_valid ? e0_instr_q : NOP_INSTR;
    assign out_pc       = out_valid ? e0_pc_q : 32'h0000_0000;
    assign out_pc_plus4 = out_pc + 32'd4;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: default-PC instance plus a wrap-around RESET_PC instance.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_ready;

    logic [31:0] a_addr, a_data, a_instr, a_pc, a_pc4;
    logic        a_valid, a_err;
    logic [31:0] b_addr, b_data, b_instr, b_pc, b_pc4;
    logic        b_valid, b_err;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] W0   = 32'h0110_0233;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a == 32'h0000_0000) ? W0 : (32'hC0DE_0000 ^ a);
    endfunction

    assign a_data = rom(a_addr);
    assign b_data = rom(b_addr);

    instr_fetch dut_a (
        .clk(clk), .reset(reset), .imem_addr(a_addr), .imem_data(a_data),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .out_valid(a_valid), .out_ready(out_ready), .out_instr(a_instr),
        .out_pc(a_pc), .out_pc_plus4(a_pc4), .misalign_err(a_err)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .reset(reset), .imem_addr(b_addr), .imem_data(b_data),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .out_valid(b_valid), .out_ready(out_ready), .out_instr(b_instr),
        .out_pc(b_pc), .out_pc_plus4(b_pc4), .misalign_err(b_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0; out_ready = 1'b1;
        step(); step();
        chk1("rst_valid", a_valid, 1'b0);
        chk("rst_instr", a_instr, NOP);
        chk("rst_pc", a_pc, 32'h0);
        chk("rst_addr", a_addr, 32'h0);
        chk1("rst_err", a_err, 1'b0);
        chk("rst_addr_b", b_addr, 32'hFFFF_FFF8);

        // Streaming with out_ready held high; instance b wraps through zero.
        reset = 1'b0;
        step();
        chk1("s0_valid", a_valid, 1'b1);
        chk("s0_pc", a_pc, 32'h0);
        chk("s0_instr", a_instr, W0);
        chk("s0_pc4", a_pc4, 32'h4);
        chk("s0_pc_b", b_pc, 32'hFFFF_FFF8);
        step();
        chk("s1_pc", a_pc, 32'h4);
        chk("s1_instr", a_instr, 32'hC0DE_0004);
        chk("s1_pc_b", b_pc, 32'hFFFF_FFFC);
        chk("s1_pc4_b", b_pc4, 32'h0);
        step();
        chk("s2_pc", a_pc, 32'h8);
        chk("s2_pc_b", b_pc, 32'h0);
        chk("s2_instr_b", b_instr, W0);
        step();
        chk("s3_pc", a_pc, 32'hC);
        chk("s3_pc4", a_pc4, 32'h10);

        // Backpressure: buffer fills to two entries and stalls the PC.
        reset = 1'b1; out_ready = 1'b0;
        step();
        chk1("rst2_valid", a_valid, 1'b0);
        reset = 1'b0;
        step();
        chk("bp0_addr", a_addr, 32'h4);
        for (int i = 1; i < 6; i++) begin
            step();
            chk("bp_addr", a_addr, 32'h8);
            chk("bp_pc", a_pc, 32'h0);
            chk("bp_instr", a_instr, W0);
            chk1("bp_valid", a_valid, 1'b1);
        end
        out_ready = 1'b1;
        step();
        chk("bp_rel1", a_pc, 32'h4);
        chk1("bp_rel1_v", a_valid, 1'b1);
        step();
        chk("bp_rel2", a_pc, 32'h8);
        chk1("bp_rel2_v", a_valid, 1'b1);
        chk("bp_rel2_addr", a_addr, 32'h10);

        // Redirect from FULL together with an accepted head.
        reset = 1'b1; out_ready = 1'b0;
        step();
        reset = 1'b0;
        step(); step();
        chk("full_addr", a_addr, 32'h8);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'd32;
        chk("rd_head", a_pc, 32'h0);
        step();
        redirect_valid = 1'b0;
        chk1("rd_flush_v", a_valid, 1'b0);
        chk("rd_flush_instr", a_instr, NOP);
        chk("rd_flush_pc", a_pc, 32'h0);
        chk("rd_addr", a_addr, 32'd32);
        step();
        chk1("rd_t0_v", a_valid, 1'b1);
        chk("rd_t0", a_pc, 32'd32);
        chk("rd_t0_instr", a_instr, 32'hC0DE_0020);
        step();
        chk("rd_t1", a_pc, 32'd36);

        // Misaligned redirect target.
        redirect_valid = 1'b1; redirect_target = 32'h0000_0022;
        step();
        redirect_valid = 1'b0;
        chk1("mis_v0", a_valid, 1'b0);
`ifdef MISALIGN_CHK_EN
        chk1("mis_err", a_err, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk1("mis_halt_v", a_valid, 1'b0);
            chk1("mis_sticky", a_err, 1'b1);
        end
        reset = 1'b1;
        step();
        chk1("mis_rst_err", a_err, 1'b0);
        chk1("mis_rst_v", a_valid, 1'b0);
        reset = 1'b0;
        step();
        chk1("mis_resume_v", a_valid, 1'b1);
        chk("mis_resume_pc", a_pc, 32'h0);
`else
        chk1("mis_err", a_err, 1'b0);
        step();
        chk1("mis_v1", a_valid, 1'b1);
        chk("mis_pc", a_pc, 32'h20);
        chk1("mis_err2", a_err, 1'b0);
        step();
        chk("mis_pc2", a_pc, 32'h24);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
